// File: rtl/dmem_ctrl.sv
// Single-port, one-request-per-cycle data memory for the MEM stage, zero-filled after reset.
// Optional byte parity checking is compiled in with `define DMEM_PARITY_EN.
module dmem_ctrl #(
    parameter int          DEPTH     = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [63:0] reqAddr,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [63:0] reqWdata,
    output logic        respValid,
    output logic [63:0] respRdata,
    output logic        respFault,
    output logic        initBusy
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: a request transfers on a rising edge where reqValid && reqReady;
    // exactly one respValid pulse follows on the next cycle, with no backpressure on responses.

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state, stateNext;
    logic [AW-1:0] initPtr, initPtrNext;

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            initPtr <= '0;
        end else begin
            state   <= stateNext;
            initPtr <= initPtrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        initPtrNext = initPtr;
        reqReady    = 1'b0;
        initBusy    = 1'b0;
        case (state)
            ST_INIT: begin
                initBusy    = 1'b1;
                initPtrNext = initPtr + 1'b1;
                if (initPtr == AW'(DEPTH - 1)) stateNext = ST_RUN;
            end
            ST_RUN: begin
                reqReady = 1'b1;
            end
            default: stateNext = ST_INIT;
        endcase
    end

    logic [63:0]   off;
    logic [AW-1:0] wordIdx;
    logic [2:0]    lane;
    logic          outOfRange;
    logic          misaligned;
    logic          fault;
    logic          accept;
    logic          doStore;

    assign off        = reqAddr - BASE_ADDR;
    assign wordIdx    = off[AW+2:3];
    assign lane       = off[2:0];
    assign outOfRange = (reqAddr < BASE_ADDR) || (off[63:AW+3] != '0);
    assign fault      = outOfRange || misaligned;
    assign accept     = reqValid && reqReady;
    assign doStore    = accept && reqWrite && !fault;

    always_comb begin
        misaligned = 1'b0;
        case (reqSize)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lane[0];
            2'd2:    misaligned = |lane[1:0];
            default: misaligned = |lane;
        endcase
    end

    logic [7:0]  sizeMask;
    logic [7:0]  byteEn;
    logic [63:0] wdataSh;
    logic [63:0] rdWord;
    logic [63:0] storeWord;
    logic [63:0] shifted;
    logic [63:0] loadData;

    always_comb begin
        sizeMask = 8'h01;
        case (reqSize)
            2'd0:    sizeMask = 8'h01;
            2'd1:    sizeMask = 8'h03;
            2'd2:    sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
    end

    assign byteEn  = sizeMask << lane;
    assign wdataSh = reqWdata << {lane, 3'b000};
    // Combinational read sees a store committed on the previous edge, which gives read-after-write for free.
    assign rdWord  = mem[wordIdx];
    assign shifted = rdWord >> {lane, 3'b000};

    always_comb begin
        storeWord = rdWord;
        for (int b = 0; b < 8; b++) begin
            if (byteEn[b]) storeWord[8*b +: 8] = wdataSh[8*b +: 8];
        end
    end

    always_comb begin
        loadData = shifted;
        case (reqSize)
            2'd0:    loadData = {{56{reqSigned & shifted[7]}},  shifted[7:0]};
            2'd1:    loadData = {{48{reqSigned & shifted[15]}}, shifted[15:0]};
            2'd2:    loadData = {{32{reqSigned & shifted[31]}}, shifted[31:0]};
            default: loadData = shifted;
        endcase
    end

`ifdef DMEM_PARITY_EN
    logic [7:0] par [DEPTH];
    logic       parErr;

    function automatic logic [7:0] bytePar(input logic [63:0] w);
        logic [7:0] p;
        for (int b = 0; b < 8; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    assign parErr = !reqWrite && (|(byteEn & (bytePar(rdWord) ^ par[wordIdx])));

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[initPtr] <= '0;
            par[initPtr] <= '0;
        end else if (doStore) begin
            mem[wordIdx] <= storeWord;
            par[wordIdx] <= bytePar(storeWord);
        end
    end
`else
    logic parErr;

    assign parErr = 1'b0;

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[initPtr] <= '0;
        end else if (doStore) begin
            mem[wordIdx] <= storeWord;
        end
    end
`endif

    // Data and fault only change on an accepted request so they hold across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respValid <= 1'b0;
            respRdata <= '0;
            respFault <= 1'b0;
        end else begin
            respValid <= accept;
            if (accept) begin
                respFault <= fault || parErr;
                respRdata <= (reqWrite || fault || parErr) ? 64'h0 : loadData;
            end
        end
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data memory for the ARMv8 datapath MEM stage; replaces the fixed 256x64 data memory.
- Supports byte/half/word/doubleword loads and stores with byte-lane writes, sign/zero extension on loads, and alignment/range fault reporting.
- Zero-fills its array after reset using an internal init state machine.
- Single port, fully pipelined, one request per cycle.

Parameters:
- DEPTH, 256, number of 64-bit words; power of 2, minimum 2.
- BASE_ADDR, 64'h0, byte address of word 0; must be 8-byte aligned.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  controller can accept a request this cycle.
- reqWrite  in  1  1 = store, 0 = load.
- reqAddr  in  64  byte address.
- reqSize  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = doubleword.
- reqSigned  in  1  load result is sign-extended when 1; ignored for stores.
- reqWdata  in  64  store data, right-justified (low bytes used).
- respValid  out  1  one-cycle pulse, one per accepted request.
- respRdata  out  64  load result; 0 for stores and faults.
- respFault  out  1  request was misaligned or out of range.
- initBusy  out  1  zero-fill in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - reqReady=0, respValid=0, respRdata=0, respFault=0, initBusy=1.
  - FSM enters INIT with initPtr=0.
- FSM INIT:
  - Each cycle writes 64'h0 to mem[initPtr], then increments initPtr.
  - After writing index DEPTH-1, moves to RUN. INIT lasts exactly DEPTH cycles after reset release.
  - reqReady=0 throughout; requests are ignored.
- FSM RUN: reqReady=1, initBusy=0. RUN has no exit except reset.
- Accept condition: reqValid && reqReady at a rising edge.
- Address decoding:
  - off = reqAddr - BASE_ADDR (64-bit unsigned).
  - Word index = off[log2(DEPTH)+2:3].
  - Lane = off[2:0].
  - nbytes = 1 << reqSize.
- Fault conditions (either one sets the fault):
  - Misaligned: (lane & (nbytes-1)) != 0.
  - Out of range: reqAddr < BASE_ADDR, or off >= DEPTH*8.
  - A faulting request never modifies memory. The following cycle gives respValid=1, respFault=1, respRdata=0.
- Store (no fault):
  - Bytes lane .. lane+nbytes-1 of the word take reqWdata bytes 0 .. nbytes-1 at the accept edge.
  - All other bytes are unchanged.
  - Following cycle: respValid=1, respFault=0, respRdata=0.
- Load (no fault):
  - Following cycle: respValid=1, respFault=0.
  - respRdata = the nbytes bytes starting at lane, right-justified.
  - Upper bits are copies of the MSB of the loaded field if reqSigned=1, otherwise zeros.
  - Doubleword loads ignore reqSigned.
- Latency and throughput: exactly 1 cycle from accept to respValid. Back-to-back requests give back-to-back responses with no bubbles.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes.
- When no request was accepted in the previous cycle: respValid=0; respRdata and respFault hold their last values.
- Reset mid-operation: any in-flight response is dropped, and INIT restarts from index 0.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- With the macro defined:
  - An 8-bit parity array stores the even parity of each byte.
  - Parity bits are updated on every byte write, including INIT.
  - On a non-faulting load, a parity mismatch in any accessed byte sets respFault=1 and forces respRdata=0.
  - A testbench-only task flips one stored data bit to exercise this.
- Without the macro: no parity storage; respFault reflects only alignment and range faults.

Test Plan:
- Init: release rst_n; reqReady is 0 for exactly DEPTH (256) cycles, then 1. A doubleword load at addr 0x0F8 returns 0.
- Store/load sizes:
  - Store dword 0x1122334455667788 at 0x10.
  - Load byte at 0x13, signed -> 0x0000000000000055.
  - Store half 0xBEEF at 0x14; load dword at 0x10 -> 0x1122BEEF55667788.
  - Load half at 0x14, signed -> 0xFFFFFFFFFFFFBEEF; unsigned -> 0x000000000000BEEF.
- Faults:
  - Word load at 0x12 -> respFault=1, respRdata=0.
  - Dword store at DEPTH*8 (0x800) -> respFault=1, and a subsequent load of 0x7F8 is unchanged.
- Pipelining: a store at 0x20 followed immediately by a load at 0x20 on consecutive cycles gives two consecutive respValid pulses; the load returns the stored value.
- Reset mid-stream: assert rst_n low during a burst of requests. No respValid occurs after reset; initBusy=1; all previously written words read 0 after INIT.
- DMEM_PARITY_EN: flip bit 3 of the stored byte at 0x10, then load byte 0x10 -> respFault=1. Load byte 0x11 -> respFault=0.
